// File: rtl/schmidl_cox_preamble_inserter.sv
// Prepends a Schmidl-Cox training preamble to each AXI-Stream frame.
// The preamble is a cyclic prefix followed by two identical half-sequences.
module schmidl_cox_preamble_inserter #(
  parameter int HALF_LEN = 64,
  parameter int CP_LEN   = 16,
  parameter int ADDR_W   = $clog2(HALF_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic              pre_wr_en,
  input  logic [ADDR_W-1:0] pre_wr_addr,
  input  logic [31:0]       pre_wr_data,
  output logic              busy,
  input  logic [31:0]       i_tdata,
  input  logic              i_tlast,
  input  logic              i_tvalid,
  output logic              i_tready,
  output logic [31:0]       o_tdata,
  output logic              o_tlast,
  output logic              o_tvalid,
  input  logic              o_tready,
  output logic [15:0]       frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CP,
    S_HALF1,
    S_HALF2,
    S_PAYLOAD
  } state_t;

  localparam logic [ADDR_W-1:0] CP_BASE   = ADDR_W'(HALF_LEN - CP_LEN);
  localparam logic [ADDR_W-1:0] CP_LAST   = ADDR_W'((CP_LEN > 0) ? CP_LEN - 1 : 0);
  localparam logic [ADDR_W-1:0] HALF_LAST = ADDR_W'(HALF_LEN - 1);

  logic [31:0]       seq [HALF_LEN];
  state_t            state, state_d;
  logic [ADDR_W-1:0] cnt, cnt_d, rd_addr;
  logic [31:0]       tdata_d;
  logic              tvalid_d, tlast_d, start, load, pass;

  // Sequence memory has no reset so its contents survive reset and clear.
  always_ff @(posedge clk) begin
    if (pre_wr_en && !busy) seq[pre_wr_addr] <= pre_wr_data;
  end

  assign busy     = (state != S_IDLE);
  assign load     = !o_tvalid || o_tready;
  assign pass     = (state == S_PAYLOAD) || (state == S_IDLE && !enable);
  assign i_tready = pass && load && !reset;
  assign rd_addr  = (state == S_CP) ? CP_BASE + cnt : cnt;

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    tdata_d  = o_tdata;
    tvalid_d = o_tvalid;
    tlast_d  = o_tlast;
    start    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enable) begin
          if (load) tvalid_d = 1'b0;
          // Frame start does not consume the beat; PAYLOAD picks it up later.
          if (i_tvalid) begin
            start   = 1'b1;
            cnt_d   = '0;
            state_d = (CP_LEN > 0) ? S_CP : S_HALF1;
          end
        end else if (load) begin
          tvalid_d = i_tvalid;
          tdata_d  = i_tdata;
          tlast_d  = i_tlast;
        end
      end
      S_CP, S_HALF1, S_HALF2: begin
        if (load) begin
          tvalid_d = 1'b1;
          tdata_d  = seq[rd_addr];
          tlast_d  = 1'b0;
          cnt_d    = cnt + 1'b1;
          if (state == S_CP && cnt == CP_LAST) begin
            cnt_d   = '0;
            state_d = S_HALF1;
          end else if (state == S_HALF1 && cnt == HALF_LAST) begin
            cnt_d   = '0;
            state_d = S_HALF2;
          end else if (state == S_HALF2 && cnt == HALF_LAST) begin
            cnt_d   = '0;
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (load) begin
          tvalid_d = i_tvalid;
          tdata_d  = i_tdata;
          tlast_d  = i_tlast;
          if (i_tvalid && i_tlast) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      o_tdata   <= '0;
      o_tlast   <= 1'b0;
      o_tvalid  <= 1'b0;
      frame_cnt <= '0;
    end else if (clear) begin
      state    <= S_IDLE;
      cnt      <= '0;
      o_tlast  <= 1'b0;
      o_tvalid <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      o_tdata  <= tdata_d;
      o_tlast  <= tlast_d;
      o_tvalid <= tvalid_d;
      if (start) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule
